// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI gateway response path.
// Pure declarations: no logic, no latency.
// No flow control here; users apply valid/ready on rsp_entry_t transfers.
package apb2axi_pkg;

  localparam int APB_ADDR_W = 12;

  // Register window word offsets, decoded from paddr[4:2]
  localparam logic [2:0] RSP_STATUS_OFF = 3'b100;
  localparam logic [2:0] RSP_DLO_OFF    = 3'b101;
  localparam logic [2:0] RSP_DHI_OFF    = 3'b110;
  localparam logic [2:0] RSP_CTRL_OFF   = 3'b111;

  typedef struct packed {
    logic        is_write;
    logic [1:0]  resp;
    logic [63:0] data;
  } rsp_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } apb_fsm_e;

  // STATUS word; head fields are forced to zero when the FIFO is empty so
  // stale storage contents never leak out.
  function automatic logic [31:0] rsp_status_word(input rsp_entry_t head,
                                                  input logic       not_empty,
                                                  input logic [7:0] cnt,
                                                  input logic       full);
    return {15'd0, full, cnt, 4'd0,
            head.is_write & not_empty,
            head.resp & {2{not_empty}},
            not_empty};
  endfunction

endpackage

// File: rtl/apb2axi_rsp_fifo.sv
// Synchronous completion FIFO of rsp_entry_t with push, pop and flush.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is ignored when full, pop when empty; flush beats push.
module apb2axi_rsp_fifo
  import apb2axi_pkg::*;
#(
  parameter int DEPTH = 4  // power of two, at least 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  rsp_entry_t                 push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output rsp_entry_t                 head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  rsp_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

  // Pointer/occupancy next state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer/occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/apb2axi_rsp_reg.sv
// APB status/data window over a FIFO of AXI completions (offsets 0x10-0x1C).
// Latency: every APB access gets exactly one wait state, then pready for one cycle.
// Backpressure: rsp_ready drops while the FIFO is full. Optional irq via APB2AXI_RSP_IRQ_EN.
module apb2axi_rsp_reg #(
  parameter int APB_ADDR_W = apb2axi_pkg::APB_ADDR_W,  // at least 5
  parameter int RSP_DEPTH  = 4                         // power of two, at least 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic                  rsp_is_write,
  input  logic [1:0]            rsp_resp,
  input  logic [63:0]           rsp_data
`ifdef APB2AXI_RSP_IRQ_EN
  ,
  output logic                  irq
`endif
);

  import apb2axi_pkg::*;

  localparam int CNT_W = $clog2(RSP_DEPTH+1);

  apb_fsm_e         state_q, state_d;
  logic [31:0]      prdata_q, prdata_d;
  logic             pready_q, pready_d;
  logic             pslverr_q, pslverr_d;
  logic             pop_q, pop_d;
  logic             flush_q, flush_d;

  rsp_entry_t       push_dat, head_dat;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic [2:0]       offset;
  logic [31:0]      status_word;

  assign push_dat    = '{is_write: rsp_is_write, resp: rsp_resp, data: rsp_data};
  assign rsp_ready   = !fifo_full;
  assign offset      = paddr[4:2];
  assign status_word = rsp_status_word(head_dat, !fifo_empty, 8'(fifo_count), fifo_full);

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

  // Pop and flush are captured during the wait state and applied on the RESP cycle
  apb2axi_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk      (pclk),
    .rst      (preset),
    .push     (rsp_valid && rsp_ready),
    .push_dat (push_dat),
    .pop      (pop_q && (state_q == RESP)),
    .flush    (flush_q && (state_q == RESP)),
    .head_dat (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef APB2AXI_RSP_IRQ_EN
  logic mask_q, mask_d;
  logic irq_q;
  logic unused_bits;
  assign unused_bits = ^{paddr[APB_ADDR_W-1:5], paddr[1:0], pwdata[31:2]};
  assign irq = irq_q;

  // irq follows FIFO occupancy one cycle late, gated by the CTRL mask
  always_ff @(posedge pclk) begin
    if (preset) begin
      mask_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= !fifo_empty && !mask_q;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{paddr[APB_ADDR_W-1:5], paddr[1:0], pwdata[31:1]};
`endif

  // Access decode and FSM next state; responses are captured in IDLE
  always_comb begin
    state_d   = state_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    pop_d     = 1'b0;
    flush_d   = 1'b0;
`ifdef APB2AXI_RSP_IRQ_EN
    mask_d    = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (psel && penable) begin
          state_d  = RESP;
          pready_d = 1'b1;
          prdata_d = 32'd0;
          if (!paddr[4]) begin
            pslverr_d = 1'b1;
          end else if (pwrite) begin
            if (offset == RSP_CTRL_OFF) begin
              flush_d = pwdata[0];
`ifdef APB2AXI_RSP_IRQ_EN
              mask_d  = pwdata[1];
`endif
            end else begin
              pslverr_d = 1'b1;
            end
          end else begin
            case (offset)
              RSP_STATUS_OFF: prdata_d = status_word;
              RSP_DLO_OFF: begin
                if (fifo_empty) pslverr_d = 1'b1;
                else            prdata_d  = head_dat.data[31:0];
              end
              RSP_DHI_OFF: begin
                if (fifo_empty) begin
                  pslverr_d = 1'b1;
                end else begin
                  prdata_d = head_dat.data[63:32];
                  pop_d    = 1'b1;
                end
              end
              default: prdata_d = 32'd0;
            endcase
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and APB response registers
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      prdata_q  <= 32'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      pop_q     <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      pop_q     <= pop_d;
      flush_q   <= flush_d;
    end
  end

endmodule

// File: tb/tb_apb2axi_rsp_reg.sv
// Directed bench for apb2axi_rsp_reg: vector table plus multi-cycle sequences.
// Latency: expects one wait state per APB access.
// Backpressure: checks rsp_ready against FIFO fullness.
module tb_apb2axi_rsp_reg;

  localparam int AW = apb2axi_pkg::APB_ADDR_W;

  logic          pclk = 1'b0;
  logic          preset, psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata, prdata;
  logic          pready, pslverr;
  logic          rsp_valid, rsp_ready, rsp_is_write;
  logic [1:0]    rsp_resp;
  logic [63:0]   rsp_data;
`ifdef APB2AXI_RSP_IRQ_EN
  logic          irq;
`endif

  int errors = 0;
  int checks = 0;

  apb2axi_rsp_reg #(.APB_ADDR_W(AW), .RSP_DEPTH(4)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_write(rsp_is_write),
    .rsp_resp(rsp_resp), .rsp_data(rsp_data)
`ifdef APB2AXI_RSP_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 pclk = ~pclk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic w, input logic [1:0] r, input logic [63:0] d);
    @(posedge pclk); #1;
    chk("push_rsp_ready", rsp_ready, 1'b1);
    rsp_valid = 1'b1; rsp_is_write = w; rsp_resp = r; rsp_data = d;
    @(posedge pclk); #1;
    rsp_valid = 1'b0;
  endtask

  // One APB transfer; optionally pushes an entry on the RESP cycle edge.
  task automatic apb(input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                     input bit pr, input logic pw, input logic [1:0] presp,
                     input logic [63:0] pd,
                     output logic [31:0] rd, output logic err);
    int  waits;
    bit  got;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    chk("wait_state_pready_low", pready, 1'b0);
    got = 1'b0; waits = 0;
    while (!got && waits < 8) begin
      @(posedge pclk); #1;
      waits++;
      if (pready) got = 1'b1;
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL pready_timeout: got no pready within %0d cycles expected 1", waits);
      rd = 32'd0; err = 1'b1;
    end else begin
      chk("one_wait_state", 64'(waits), 64'd1);
      rd = prdata; err = pslverr;
    end
    if (pr) begin
      rsp_valid = 1'b1; rsp_is_write = pw; rsp_resp = presp; rsp_data = pd;
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; rsp_valid = 1'b0;
    chk("pready_single_cycle", pready, 1'b0);
    chk("pslverr_cleared", pslverr, 1'b0);
  endtask

  task automatic rd_chk(input string nm, input logic [AW-1:0] a,
                        input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd; logic err;
    apb(1'b0, a, 32'd0, 1'b0, 1'b0, 2'd0, 64'd0, rd, err);
    chk({nm, "_prdata"}, rd, exp_rd);
    chk({nm, "_pslverr"}, err, exp_err);
  endtask

  typedef struct {
    int          op;      // 0 push, 1 read, 2 write
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        is_w;
    logic [1:0]  resp;
    logic [63:0] data;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[21];

  function automatic logic [63:0] dpat(input int i);
    return {32'hC000_0000 | 32'(i), 32'h3000_0000 | 32'(i)};
  endfunction

  logic [31:0] rd;
  logic        err;
  logic [63:0] q[$];

  initial begin
    vecs[0]  = '{1, 12'h010, 32'h0, 1'b0, 2'd0, 64'h0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{0, 12'h000, 32'h0, 1'b0, 2'd0, 64'h1122_3344_5566_7788, 32'h0, 1'b0};
    vecs[2]  = '{1, 12'h014, 32'h0, 1'b0, 2'd0, 64'h0, 32'h5566_7788, 1'b0};
    vecs[3]  = '{1, 12'h018, 32'h0, 1'b0, 2'd0, 64'h0, 32'h1122_3344, 1'b0};
    vecs[4]  = '{1, 12'h010, 32'h0, 1'b0, 2'd0, 64'h0, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1, 12'h018, 32'h0, 1'b0, 2'd0, 64'h0, 32'h0, 1'b1};
    vecs[6]  = '{1, 12'h014, 32'h0, 1'b0, 2'd0, 64'h0, 32'h0, 1'b1};
    vecs[7]  = '{2, 12'h014, 32'h1, 1'b0, 2'd0, 64'h0, 32'h0, 1'b1};
    vecs[8]  = '{1, 12'h000, 32'h0, 1'b0, 2'd0, 64'h0, 32'h0, 1'b1};
    vecs[9]  = '{2, 12'h010, 32'h0, 1'b0, 2'd0, 64'h0, 32'h0, 1'b1};
    vecs[10] = '{1, 12'h01C, 32'h0, 1'b0, 2'd0, 64'h0, 32'h0, 1'b0};
    vecs[11] = '{0, 12'h000, 32'h0, 1'b1, 2'b10, 64'hAAAA_BBBB_CCCC_DDDD, 32'h0, 1'b0};
    vecs[12] = '{1, 12'h010, 32'h0, 1'b0, 2'd0, 64'h0, 32'h0000_010D, 1'b0};
    vecs[13] = '{0, 12'h000, 32'h0, 1'b0, 2'b01, 64'h0102_0304_0506_0708, 32'h0, 1'b0};
    vecs[14] = '{1, 12'h010, 32'h0, 1'b0, 2'd0, 64'h0, 32'h0000_020D, 1'b0};
    vecs[15] = '{1, 12'h018, 32'h0, 1'b0, 2'd0, 64'h0, 32'hAAAA_BBBB, 1'b0};
    vecs[16] = '{1, 12'h010, 32'h0, 1'b0, 2'd0, 64'h0, 32'h0000_0103, 1'b0};
    vecs[17] = '{1, 12'h014, 32'h0, 1'b0, 2'd0, 64'h0, 32'h0506_0708, 1'b0};
    vecs[18] = '{1, 12'h018, 32'h0, 1'b0, 2'd0, 64'h0, 32'h0102_0304, 1'b0};
    vecs[19] = '{1, 12'h010, 32'h0, 1'b0, 2'd0, 64'h0, 32'h0000_0000, 1'b0};
    vecs[20] = '{2, 12'h00C, 32'h0, 1'b0, 2'd0, 64'h0, 32'h0, 1'b1};

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    rsp_valid = 1'b0; rsp_is_write = 1'b0; rsp_resp = 2'd0; rsp_data = 64'd0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    chk("reset_pready", pready, 1'b0);
    chk("reset_prdata", prdata, 32'd0);
    chk("reset_pslverr", pslverr, 1'b0);
    chk("reset_rsp_ready", rsp_ready, 1'b1);
`ifdef APB2AXI_RSP_IRQ_EN
    chk("reset_irq", irq, 1'b0);
`endif

    for (int i = 0; i < 21; i++) begin
      case (vecs[i].op)
        0: push(vecs[i].is_w, vecs[i].resp, vecs[i].data);
        default: begin
          apb(vecs[i].op == 2, AW'(vecs[i].addr), vecs[i].wdata, 1'b0, 1'b0, 2'd0, 64'd0, rd, err);
          chk($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
          chk($sformatf("vec%0d_pslverr", i), err, vecs[i].exp_err);
        end
      endcase
    end

    // Fill to full, hold off a fifth entry, then free one slot with a pop
    push(1'b1, 2'b11, 64'h0000_0001_0000_00A0);
    push(1'b0, 2'b00, 64'h0000_0002_0000_00A1);
    push(1'b0, 2'b00, 64'h0000_0003_0000_00A2);
    push(1'b0, 2'b00, 64'h0000_0004_0000_00A3);
    chk("full_rsp_ready", rsp_ready, 1'b0);
    rd_chk("full_status", AW'(12'h010), 32'h0001_040F, 1'b0);
    rsp_valid = 1'b1; rsp_data = 64'hDEAD_DEAD_DEAD_DEAD;
    repeat (3) @(posedge pclk);
    #1 chk("held_off_rsp_ready", rsp_ready, 1'b0);
    rsp_valid = 1'b0;
    rd_chk("held_off_status", AW'(12'h010), 32'h0001_040F, 1'b0);
    rd_chk("full_pop", AW'(12'h018), 32'h0000_0001, 1'b0);
    chk("rdy_after_pop", rsp_ready, 1'b1);
    rd_chk("after_pop_status", AW'(12'h010), 32'h0000_0301, 1'b0);

    // Flush with three queued and a push landing on the same edge
    apb(1'b1, AW'(12'h01C), 32'h1, 1'b1, 1'b0, 2'd0, 64'hBEEF, rd, err);
    chk("flush_pslverr", err, 1'b0);
    rd_chk("flush_status", AW'(12'h010), 32'h0000_0000, 1'b0);
    rd_chk("flush_dlo_empty", AW'(12'h014), 32'h0, 1'b1);

    // Pop and push on the same edge; order kept across pointer wrap
    push(1'b0, 2'd0, dpat(0)); q.push_back(dpat(0));
    push(1'b0, 2'd0, dpat(1)); q.push_back(dpat(1));
    for (int k = 0; k < 9; k++) begin
      rd_chk($sformatf("wrap%0d_lo", k), AW'(12'h014), q[0][31:0], 1'b0);
      apb(1'b0, AW'(12'h018), 32'd0, 1'b1, 1'b0, 2'd0, dpat(k+2), rd, err);
      chk($sformatf("wrap%0d_hi", k), rd, q[0][63:32]);
      chk($sformatf("wrap%0d_hi_err", k), err, 1'b0);
      void'(q.pop_front());
      q.push_back(dpat(k+2));
      rd_chk($sformatf("wrap%0d_status", k), AW'(12'h010), 32'h0000_0201, 1'b0);
    end
    while (q.size() > 0) begin
      rd_chk("drain_lo", AW'(12'h014), q[0][31:0], 1'b0);
      rd_chk("drain_hi", AW'(12'h018), q[0][63:32], 1'b0);
      void'(q.pop_front());
    end
    rd_chk("drain_status", AW'(12'h010), 32'h0000_0000, 1'b0);

    // Reset during the wait state abandons the transfer and empties the FIFO
    push(1'b1, 2'b01, 64'h5555_6666_7777_8888);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = AW'(12'h010);
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    @(posedge pclk); #1;
    chk("rst_mid_pready", pready, 1'b0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    repeat (2) @(posedge pclk);
    #1 chk("rst_mid_no_late_pready", pready, 1'b0);
    chk("rst_mid_rsp_ready", rsp_ready, 1'b1);
    rd_chk("rst_mid_status", AW'(12'h010), 32'h0000_0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb2axi_rsp_reg.md
Name: apb2axi_rsp_reg

Overview:
APB read-side responder for the APB-to-AXI gateway. It buffers AXI completions (response code, direction, 64-bit read data) in a small FIFO and lets the APB host read and retire them through a status/data register window at offsets 0x10-0x1C. It complements the write-only command register block by returning results over APB with one wait state per access.

Parameters:
APB_ADDR_W, apb2axi_pkg::APB_ADDR_W, APB address width
RSP_DEPTH, 4, completion FIFO depth; must be a power of two and at least 2

Ports:
pclk  in  1  APB clock, the only clock
preset  in  1  synchronous active-high reset
psel  in  1  APB select for this block's window
penable  in  1  APB access phase
pwrite  in  1  APB direction
paddr  in  APB_ADDR_W  APB address; only paddr[4:2] decoded
pwdata  in  32  APB write data
prdata  out  32  APB read data, registered
pready  out  1  APB ready, registered
pslverr  out  1  APB error, registered, valid only with pready
rsp_valid  in  1  completion entry valid
rsp_ready  out  1  FIFO can accept; equals (count != RSP_DEPTH)
rsp_is_write  in  1  completion belongs to a write
rsp_resp  in  2  AXI BRESP/RRESP
rsp_data  in  64  read data; don't-care for writes

Behaviour:
- Reset, sampled on posedge pclk with preset=1: FSM to IDLE; prdata=0, pready=0, pslverr=0; FIFO emptied (count=0, pointers=0). A transfer in progress when reset asserts is abandoned and is not completed.
- Push: an entry is written when rsp_valid && rsp_ready. rsp_ready is combinational from count. A pop in the same cycle does not raise rsp_ready in that cycle.
- Register map, word offsets on paddr[4:2]:
  - 100 STATUS (RO): [0] not_empty, [2:1] head resp, [3] head is_write, [15:8] count zero-extended, [16] full, others 0.
  - 101 DATA_LO (RO): head data[31:0].
  - 110 DATA_HI (RO): head data[63:32]; a successful read pops the head.
  - 111 CTRL: write bit0=1 flushes the FIFO; reads return 0.
- FSM has two states, IDLE and RESP.
  - IDLE: pready=0. On psel && penable, decode and capture prdata/pslverr, then go to RESP. This gives exactly one wait state.
  - RESP: pready=1 for exactly one cycle with the captured prdata/pslverr, then back to IDLE; pslverr returns to 0.
- The APB setup phase (psel && !penable) is ignored.
- Error rules (pslverr=1, prdata=0, no state change):
  - paddr[4]=0.
  - Read of DATA_LO or DATA_HI while empty.
  - Write to any offset other than CTRL.
  - Read of STATUS while empty is legal and returns not_empty=0.
- Pop and flush both take effect on the RESP cycle.
  - Pop with a push in the same cycle: count unchanged, both pointers advance.
  - Flush wins over a same-cycle push: the pushed entry is discarded.
- Pointers wrap modulo RSP_DEPTH. count is $clog2(RSP_DEPTH+1) bits wide.
- prdata is captured in IDLE from the head entry present in that cycle. A push arriving in the same cycle into an empty FIFO is not visible until the next access.

Optional Feature:
APB2AXI_RSP_IRQ_EN
- When defined: adds output port irq (1 bit, registered). Reset value is 0. irq goes high the cycle after count becomes non-zero and low the cycle after the FIFO becomes empty. CTRL bit1 written as 1 masks irq; the mask resets to 0 (unmasked).
- When undefined: no irq port, no mask flop, and CTRL bit1 is ignored.

Decomposition:
- apb2axi_pkg: rsp_entry_t packed struct {is_write, resp[1:0], data[63:0]}; offset localparams RSP_STATUS_OFF=3'b100, RSP_DLO_OFF=3'b101, RSP_DHI_OFF=3'b110, RSP_CTRL_OFF=3'b111; apb_fsm_e {IDLE, RESP}.
- Sub-module apb2axi_rsp_fifo (synchronous FIFO of rsp_entry_t with push, pop, flush, count, full, empty); the register/FSM logic stays in the top.

Test Plan:
- Reset, then read STATUS → pready low 1 cycle, then high; prdata=0x0000_0000; pslverr=0.
- Push {is_write=0, resp=0, data=0x1122_3344_5566_7788}; read DATA_LO → 0x5566_7788; read DATA_HI → 0x1122_3344; then STATUS → 0 (popped).
- Push 4 entries (RSP_DEPTH=4) → rsp_ready=0, STATUS=0x0001_0401 | head bits; a 5th rsp_valid is held off; one DATA_HI pop → rsp_ready=1 the next cycle.
- Read DATA_HI when empty → pslverr=1, prdata=0, count stays 0; write to 0x14 → pslverr=1.
- Pop on the RESP cycle while rsp_valid is pushed → count unchanged (2→2), FIFO order preserved across pointer wrap after 9 push/pop pairs.
- Write CTRL=0x1 with 3 entries queued and a same-cycle push → count=0; assert preset during a wait state → pready=0, FSM IDLE, FIFO empty.
